// File: rtl/mips_defs.sv
// Shared MIPS definitions: branch/jump opcode and funct encodings, CP0
// exception codes, and default instruction-memory geometry.
package mips_defs;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] EXC_ADEL   = 5'd4;

  localparam logic [31:0] IM_BASE_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_SIZE_DEFAULT = 32'h0000_1000;
  localparam logic [31:0] NOP_DEFAULT     = 32'h0000_0000;

endpackage

// File: rtl/if_is_branch.sv
// Combinational branch/jump detector; shared by the IF/ID register and decode.
module if_is_branch
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output logic        is_branch
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // NOTE: default assignment first so every path drives is_branch (no latch).
  always_comb begin
    is_branch = 1'b0;
    case (opcode)
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
      OP_SPECIAL: is_branch = (funct == FN_JR) || (funct == FN_JALR);
      default:    is_branch = 1'b0;
    endcase
  end

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with stall, flush, AdEL fetch exception and BD flag.
// Define IF_ID_PC_RANGE_CHECK_EN to also fault on PCs outside instruction memory.
module if_id_reg
  import mips_defs::*;
#(
  parameter logic [31:0] IM_BASE   = IM_BASE_DEFAULT,
  parameter logic [31:0] IM_SIZE   = IM_SIZE_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        ExcFlush,
  input  logic [31:0] PC4_F,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC4_D,
  output logic [31:0] PC_D,
  output logic [31:0] Instr_D,
  output logic        Valid_D,
  output logic        BD_D,
  output logic        ExcValid_D,
  output logic [4:0]  ExcCode_D
);

  logic [31:0] pc_f;
  logic        fetch_fault;
  logic        d_is_branch;

  assign pc_f = PC4_F - 32'd4;

`ifdef IF_ID_PC_RANGE_CHECK_EN
  assign fetch_fault = (pc_f[1:0] != 2'b00) || (pc_f < IM_BASE) ||
                       (pc_f >= IM_BASE + IM_SIZE);
`else
  wire [63:0] unused_range_cfg = {IM_BASE, IM_SIZE};
  assign fetch_fault = (pc_f[1:0] != 2'b00);
`endif

  // The instruction now in D decides whether the incoming one sits in its delay slot.
  if_is_branch u_is_branch (
    .instr     (Instr_D),
    .is_branch (d_is_branch)
  );

  assign PC_D      = PC4_D - 32'd4;
  assign ExcCode_D = ExcValid_D ? EXC_ADEL : 5'd0;

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous here.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC4_D      <= 32'd0;
      Instr_D    <= NOP_INSTR;
      Valid_D    <= 1'b0;
      BD_D       <= 1'b0;
      ExcValid_D <= 1'b0;
    end else if (ExcFlush || (FlushD && !StallD)) begin
      PC4_D      <= PC4_F;
      Instr_D    <= NOP_INSTR;
      Valid_D    <= 1'b0;
      BD_D       <= 1'b0;
      ExcValid_D <= 1'b0;
    end else if (!StallD) begin
      PC4_D      <= PC4_F;
      Instr_D    <= fetch_fault ? NOP_INSTR : Instr_F;
      Valid_D    <= 1'b1;
      BD_D       <= Valid_D && d_is_branch;
      ExcValid_D <= fetch_fault;
    end
  end

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset, StallD, FlushD, ExcFlush;
  logic [31:0] PC4_F, Instr_F;
  logic [31:0] PC4_D, PC_D, Instr_D;
  logic        Valid_D, BD_D, ExcValid_D;
  logic [4:0]  ExcCode_D;

  int vectors    = 0;
  int miscompares = 0;

  localparam logic [31:0] BEQ = 32'h1109_0003;
  localparam logic [31:0] ORI = 32'h3508_0001;
  localparam logic [31:0] ADDI = 32'h2008_0001;
  localparam logic [31:0] JR  = 32'h03E0_0008;

`ifdef IF_ID_PC_RANGE_CHECK_EN
  localparam bit RANGE_ON = 1'b1;
`else
  localparam bit RANGE_ON = 1'b0;
`endif

  if_id_reg dut (
    .clk        (clk),
    .reset      (reset),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .ExcFlush   (ExcFlush),
    .PC4_F      (PC4_F),
    .Instr_F    (Instr_F),
    .PC4_D      (PC4_D),
    .PC_D       (PC_D),
    .Instr_D    (Instr_D),
    .Valid_D    (Valid_D),
    .BD_D       (BD_D),
    .ExcValid_D (ExcValid_D),
    .ExcCode_D  (ExcCode_D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc4, input logic [31:0] instr);
    PC4_F   = pc4;
    Instr_F = instr;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".pc4"},   PC4_D, 32'd0);
    check({tag, ".pc"},    PC_D, 32'hFFFF_FFFC);
    check({tag, ".instr"}, Instr_D, 32'd0);
    check({tag, ".valid"}, {31'd0, Valid_D}, 32'd0);
    check({tag, ".bd"},    {31'd0, BD_D}, 32'd0);
    check({tag, ".exc"},   {31'd0, ExcValid_D}, 32'd0);
    check({tag, ".code"},  {27'd0, ExcCode_D}, 32'd0);
  endtask

  task automatic check_fault(input string tag, input bit exp_fault, input logic [31:0] instr);
    check({tag, ".instr"}, Instr_D, exp_fault ? 32'd0 : instr);
    check({tag, ".exc"},   {31'd0, ExcValid_D}, {31'd0, exp_fault});
    check({tag, ".code"},  {27'd0, ExcCode_D}, exp_fault ? 32'd4 : 32'd0);
    check({tag, ".valid"}, {31'd0, Valid_D}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; StallD = 1'b0; FlushD = 1'b0; ExcFlush = 1'b0;
    drive(32'h3004, ADDI);

    // Reset held for two cycles, then release
    step(); check_reset_vals("rst1");
    step(); check_reset_vals("rst2");
    reset = 1'b0;
    step();
    check("rel.pc4",   PC4_D, 32'h3004);
    check("rel.pc",    PC_D, 32'h3000);
    check("rel.instr", Instr_D, ADDI);
    check("rel.valid", {31'd0, Valid_D}, 32'd1);
    check("rel.exc",   {31'd0, ExcValid_D}, 32'd0);
    check("rel.bd",    {31'd0, BD_D}, 32'd0);

    // Stall holds for three cycles while F changes
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(32'h3008 + 32'(i * 4), ORI);
      step();
      check("stall.pc4",   PC4_D, 32'h3004);
      check("stall.instr", Instr_D, ADDI);
      check("stall.valid", {31'd0, Valid_D}, 32'd1);
    end
    FlushD = 1'b1;
    step();
    check("stallflush.instr", Instr_D, ADDI);
    check("stallflush.valid", {31'd0, Valid_D}, 32'd1);

    // FlushD alone bubbles, PC4 still loads
    StallD = 1'b0;
    drive(32'h3010, ORI);
    step();
    check("flush.instr", Instr_D, 32'd0);
    check("flush.valid", {31'd0, Valid_D}, 32'd0);
    check("flush.pc4",   PC4_D, 32'h3010);

    // ExcFlush overrides StallD
    FlushD = 1'b0;
    drive(32'h300C, ADDI);
    step();
    check("pre_exc.valid", {31'd0, Valid_D}, 32'd1);
    StallD = 1'b1; ExcFlush = 1'b1;
    drive(32'h3010, ORI);
    step();
    check("excflush.instr", Instr_D, 32'd0);
    check("excflush.valid", {31'd0, Valid_D}, 32'd0);
    check("excflush.pc4",   PC4_D, 32'h3010);
    StallD = 1'b0; ExcFlush = 1'b0;

    // Delay slot after beq
    drive(32'h3004, BEQ);  step(); check("beq.bd", {31'd0, BD_D}, 32'd0);
    drive(32'h3008, ORI);  step(); check("beq_ds.bd", {31'd0, BD_D}, 32'd1);
    drive(32'h300C, ADDI); step(); check("after_ds.bd", {31'd0, BD_D}, 32'd0);
    // Delay slot after jr
    drive(32'h3010, JR);   step(); check("jr.bd", {31'd0, BD_D}, 32'd0);
    drive(32'h3014, ORI);  step(); check("jr_ds.bd", {31'd0, BD_D}, 32'd1);
    // Bubble between beq and its successor
    drive(32'h3018, BEQ);  step();
    FlushD = 1'b1; drive(32'h301C, ORI); step();
    check("bubble.bd",    {31'd0, BD_D}, 32'd0);
    check("bubble.valid", {31'd0, Valid_D}, 32'd0);
    FlushD = 1'b0; step();
    check("post_bubble.bd", {31'd0, BD_D}, 32'd0);

    // Misaligned fetch
    drive(32'h3006, ADDI); step();
    check_fault("misalign", 1'b1, ADDI);
    check("misalign.pc4", PC4_D, 32'h3006);
    // A faulting branch never makes its successor BD
    drive(32'h300A, BEQ);  step(); check_fault("misalign_beq", 1'b1, BEQ);
    drive(32'h3010, ORI);  step(); check("fault_succ.bd", {31'd0, BD_D}, 32'd0);

    // Range boundaries
    drive(32'h4000, ADDI); step(); check_fault("last_word", 1'b0, ADDI);
    drive(32'h4004, ADDI); step(); check_fault("past_end", RANGE_ON, ADDI);
    drive(32'h3000, ADDI); step(); check_fault("below_base", RANGE_ON, ADDI);

    // Reset wins over ExcFlush
    drive(32'h3008, ORI); step();
    reset = 1'b1; ExcFlush = 1'b1; step();
    check_reset_vals("rst_exc");
    reset = 1'b0; ExcFlush = 1'b0;

    // Reset during a stall holding a BD instruction
    drive(32'h3004, BEQ); step();
    drive(32'h3008, ORI); step();
    StallD = 1'b1; drive(32'h300C, ADDI); step();
    check("stall_bd.bd", {31'd0, BD_D}, 32'd1);
    reset = 1'b1; step();
    check_reset_vals("rst_stall");
    reset = 1'b0; StallD = 1'b0;
    drive(32'h3010, ORI); step();
    check("post_rst.bd",    {31'd0, BD_D}, 32'd0);
    check("post_rst.instr", Instr_D, ORI);
    check("post_rst.valid", {31'd0, Valid_D}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_reg.md
Name: if_id_reg

Overview:
- Pipeline register between the instruction-fetch stage and decode.
- Captures PC+4 and the fetched instruction each cycle.
- Supports stall (hold), flush (bubble) and exception flush.
- Generates fetch-side exception info (AdEL on a bad PC) and the branch-delay-slot flag consumed by CP0/EPC logic downstream.

Parameters:
- IM_BASE, 32'h0000_3000, first byte address of instruction memory
- IM_SIZE, 32'h0000_1000, instruction memory size in bytes (4 KiB)
- NOP_INSTR, 32'h0000_0000, encoding inserted for bubbles and faulting fetches

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- StallD  in  1  hold D-stage contents (hazard unit)
- FlushD  in  1  insert bubble (e.g. wrong-path after eret)
- ExcFlush  in  1  exception/interrupt taken; kill D-stage, overrides StallD
- PC4_F  in  32  PC+4 from fetch
- Instr_F  in  32  instruction from fetch
- PC4_D  out  32  registered PC+4
- PC_D  out  32  PC4_D - 4, combinational from register
- Instr_D  out  32  registered instruction
- Valid_D  out  1  1 = real instruction, 0 = bubble
- BD_D  out  1  instruction in D is in a branch delay slot
- ExcValid_D  out  1  fetch exception pending on this instruction
- ExcCode_D  out  5  CP0 ExcCode; 5'd4 (AdEL) when ExcValid_D, else 0

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset). No asynchronous paths.
- Reset values: PC4_D = 0, Instr_D = NOP_INSTR, Valid_D = 0, BD_D = 0, ExcValid_D = 0, ExcCode_D = 0.
- Update priority on each rising edge:
  1. reset: apply the reset values.
  2. ExcFlush: bubble. Instr_D = NOP_INSTR, Valid_D = 0, BD_D = 0, ExcValid_D = 0, ExcCode_D = 0. PC4_D loads PC4_F so EPC logic still sees a sane PC. Wins over StallD.
  3. StallD: all registers hold. A FlushD asserted together with StallD is ignored.
  4. FlushD: bubble, same as ExcFlush.
  5. Otherwise: load from the F stage (see next items).
- Load latency: 1 cycle, F -> D.
- Fetch PC: PC_F = PC4_F - 4, 32-bit wrap.
- Fault on load when any of these holds:
  - PC_F[1:0] != 0
  - PC_F < IM_BASE (range check, see Optional Feature)
  - PC_F >= IM_BASE + IM_SIZE (range check, see Optional Feature)
- On a fault: Instr_D = NOP_INSTR, ExcValid_D = 1, ExcCode_D = 5'd4, Valid_D = 1. The instruction is still real for EPC purposes.
- No fault: Instr_D = Instr_F, ExcValid_D = 0, ExcCode_D = 0, Valid_D = 1.
- BD_D on load is 1 iff Valid_D = 1 and the current Instr_D is a branch/jump:
  - opcode 6'h02 (j), 6'h03 (jal), 6'h04 (beq), 6'h05 (bne), 6'h06 (blez), 6'h07 (bgtz), 6'h01 (REGIMM: bltz/bgez)
  - opcode 0 with funct 6'h08 (jr) or 6'h09 (jalr)
  - A faulting instruction (Instr_D = NOP_INSTR) never makes its successor BD.
- BD_D is held during stall, cleared on any bubble.
- Simultaneous ExcFlush and reset: reset wins.
- Address boundary: IM_BASE + IM_SIZE - 4 is legal; IM_BASE + IM_SIZE faults.

Optional Feature:
- Macro: IF_ID_PC_RANGE_CHECK_EN.
- Defined: fault on misalignment OR out-of-range PC, as above.
- Undefined: fault on misalignment only; the range comparators are not built and IM_BASE/IM_SIZE are unused.

Decomposition:
- Shared package/header (mips_defs):
  - opcode/funct constants for branch/jump recognition
  - EXC_ADEL = 5'd4
  - default IM_BASE/IM_SIZE values
  - NOP encoding
- One natural sub-module: if_is_branch, a combinational instruction -> 1-bit branch/jump detector. The decode stage reuses it.
- The register itself stays flat.

Test Plan:
1. Reset then release: assert reset for 2 cycles with PC4_F = 32'h3004, Instr_F = 32'h2008_0001 -> during reset all outputs are at reset values; one cycle after release PC4_D = 32'h3004, PC_D = 32'h3000, Instr_D = 32'h2008_0001, Valid_D = 1, ExcValid_D = 0.
2. Stall and flush: StallD = 1 for 3 cycles while F changes -> D holds. StallD = 1 with FlushD = 1 -> hold. FlushD alone -> Instr_D = 0, Valid_D = 0. ExcFlush with StallD = 1 -> Instr_D = 0, Valid_D = 0.
3. Delay slot: load beq (32'h1109_0003), then ori (32'h3508_0001) -> ori has BD_D = 1. Next instruction has BD_D = 0. Repeat with jr $ra (32'h03E0_0008) -> BD_D = 1. Insert a bubble between beq and the next instruction -> BD_D = 0 on the bubble.
4. Misaligned fetch: PC4_F = 32'h3006 -> Instr_D = NOP, ExcValid_D = 1, ExcCode_D = 4, Valid_D = 1.
5. Range boundary, with IF_ID_PC_RANGE_CHECK_EN defined:
   - PC4_F = 32'h4000 (PC 32'h3FFC) -> no fault.
   - PC4_F = 32'h4004 (PC 32'h4000) -> AdEL.
   - PC4_F = 32'h3000 (PC 32'h2FFC) -> AdEL.
   - With the macro undefined, the same three cases -> no fault.
6. Reset mid-stall: StallD = 1 holding a valid BD instruction, assert reset -> next edge gives reset values. The first load after release has BD_D = 0.
